// File: rtl/mult_pipe3.sv
// ============================================================================
// mult_pipe3 : two-register pipelined signed/unsigned multiplier, 2-cycle latency
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mult_pipe3 #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       tc,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int P_WIDTH  = A_WIDTH + B_WIDTH;
  localparam int LO_WIDTH = P_WIDTH / 2;
  localparam int HI_WIDTH = P_WIDTH - LO_WIDTH;

  logic [P_WIDTH-1:0]  a_ext;
  logic [P_WIDTH-1:0]  b_ext;
  logic [P_WIDTH-1:0]  pp_lo_d, pp_lo_q;
  logic [HI_WIDTH-1:0] pp_hi_d, pp_hi_q;
  logic [P_WIDTH-1:0]  product_d, product_q;

  // Extending both operands to full width makes a plain modulo-2^P multiply
  // exact for signed and unsigned alike, so tc is fully consumed here.
  always_comb begin
    a_ext = {{B_WIDTH{tc & a[A_WIDTH-1]}}, a};
    b_ext = {{A_WIDTH{tc & b[B_WIDTH-1]}}, b};
  end

  // Split the multiplier into two halves; the upper half's partial product
  // only matters modulo 2^HI_WIDTH because it is shifted up by LO_WIDTH.
  always_comb begin
    pp_lo_d = a_ext * {{HI_WIDTH{1'b0}}, b_ext[LO_WIDTH-1:0]};
    pp_hi_d = a_ext[HI_WIDTH-1:0] * b_ext[P_WIDTH-1:LO_WIDTH];
  end

  always_comb begin
    product_d = pp_lo_q + {pp_hi_q, {LO_WIDTH{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_lo_q   <= '0;
      pp_hi_q   <= '0;
      product_q <= '0;
    end else begin
      pp_lo_q   <= pp_lo_d;
      pp_hi_q   <= pp_hi_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_pipe3.sv
// ============================================================================
// tb_mult_pipe3 : self-checking bench for mult_pipe3 (vector table + scoreboard)
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mult_pipe3;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        tc;
  logic [63:0] product;

  int n_cmp;
  int n_err;

  logic [63:0] sb_q[$];

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vtc;
    logic [63:0] vexp;
  } vec_t;

  vec_t vecs[16];

  mult_pipe3 #(.A_WIDTH(32), .B_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .tc      (tc),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mtc);
    logic signed [63:0] s;
    logic [63:0]        u;
    if (mtc) begin
      s = $signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb});
      return s;
    end
    u = {32'd0, ma} * {32'd0, mb};
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipeline register 1 holds zero after reset, so one zero is already in flight.
  task automatic sb_reset();
    sb_q.delete();
    sb_q.push_back(64'd0);
  endtask

  task automatic drive_check(input string name, input logic [31:0] da, input logic [31:0] db,
                             input logic dtc, input logic [63:0] dexp);
    logic [63:0] e;
    a  = da;
    b  = db;
    tc = dtc;
    sb_q.push_back(dexp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(name, product, e);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    tc    = 1'b0;

    vecs[0]  = '{32'hFFFF_FFF9, 32'd6,         1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[1]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[2]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
    vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[5]  = '{32'd0,         32'hDEAD_BEEF, 1'b0, 64'd0};
    vecs[6]  = '{32'hDEAD_BEEF, 32'd0,         1'b1, 64'd0};
    vecs[7]  = '{32'd0,         32'hFFFF_FFFF, 1'b1, 64'd0};
    vecs[8]  = '{32'd1,         32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF};
    vecs[9]  = '{32'd1,         32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_0000_0001};
    vecs[11] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
    vecs[12] = '{32'd2,         32'h8000_0000, 1'b0, 64'h0000_0001_0000_0000};
    vecs[13] = '{32'd2,         32'h8000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000};
    vecs[14] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[15] = '{32'd3,         32'd5,         1'b0, 64'd15};

    // Reset held: product stays zero while operands toggle.
    for (int i = 0; i < 4; i++) begin
      a  = $urandom;
      b  = $urandom;
      tc = i[0];
      @(posedge clk);
      #1;
      check("reset_hold", product, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_reset();

    // Latency: 3*5 appears two edges after it is sampled, then zeros follow.
    drive_check("latency_e0", 32'd3, 32'd5, 1'b1, 64'd15);
    check("latency_after_e0", product, 64'd0);
    drive_check("latency_e1", 32'd0, 32'd0, 1'b1, 64'd0);
    check("latency_15_after_e1", product, 64'd15);
    drive_check("latency_e2", 32'd0, 32'd0, 1'b1, 64'd0);
    check("latency_0_after_e2", product, 64'd0);

    for (int i = 0; i < 16; i++)
      drive_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vtc, vecs[i].vexp);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic        rtc;
      ra  = $urandom;
      rb  = $urandom;
      rtc = (i % 3 == 0) ? 1'($urandom_range(0, 1)) : i[0];
      drive_check("stream", ra, rb, rtc, model(ra, rb, rtc));
    end

    // Async reset mid-clock: product must clear without a clock edge.
    drive_check("pre_async", 32'd7, 32'd9, 1'b0, 64'd63);
    drive_check("pre_async", 32'd7, 32'd9, 1'b0, 64'd63);
    check("pre_async_nonzero", product, 64'd63);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_reset();

    // Reset mid-stream: in-flight 7*9 results must be flushed, 2*2 follows.
    drive_check("flush_pre", 32'd7, 32'd9, 1'b0, 64'd63);
    drive_check("flush_pre", 32'd7, 32'd9, 1'b0, 64'd63);
    a  = 32'd2;
    b  = 32'd2;
    tc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("flush_during", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("flush_edge1", product, 64'd0);
    @(posedge clk);
    #1;
    check("flush_edge2", product, 64'd4);
    @(posedge clk);
    #1;
    check("flush_edge3", product, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
